// File: rtl/snoop_bus_arbiter_pkg.sv
// rtl/snoop_bus_arbiter_pkg.sv - op codes and FSM state encodings shared by the snoop bus arbiter
package snoop_bus_arbiter_pkg;

    // Op codes are the per-cache MSI controller's CDB output codes, reused unchanged on the bus.
    localparam logic [1:0] OP_RMISS = 2'b00;
    localparam logic [1:0] OP_INV   = 2'b01;
    localparam logic [1:0] OP_WMISS = 2'b10;
    localparam logic [1:0] OP_NULL  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BCAST = 3'd1,
        ST_SNOOP = 3'd2,
        ST_WB    = 3'd3,
        ST_MEM   = 3'd4,
        ST_DONE  = 3'd5
    } arb_state_e;

    function automatic logic op_is_live(input logic [1:0] op);
        return op != OP_NULL;
    endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr.sv
// rtl/snoop_bus_arbiter_rr.sv - N-way round-robin picker: request vector to one-hot grant and index
module snoop_bus_arbiter_rr #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic [N-1:0]     req_i,
    input  logic             accept_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             hi_found, lo_found;
    logic [IDX_W-1:0] hi_idx, lo_idx;

    // Lowest requester at or above the pointer wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                if (IDX_W'(i) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        valid_o = lo_found;
        idx_o   = hi_found ? hi_idx : lo_idx;
        gnt_o   = valid_o ? (N'(1) << idx_o) : '0;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (valid_o && accept_i) begin
            ptr_d = (idx_o == IDX_W'(N - 1)) ? '0 : idx_o + IDX_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - snooping coherence bus arbiter with writeback/fill sequencing
// Optional memory-wait watchdog enabled by defining ARB_TIMEOUT_EN.
module snoop_bus_arbiter
    import snoop_bus_arbiter_pkg::*;
#(
    parameter int N_CACHES = 4,
    parameter int ADDR_W   = 8,
    parameter int SRC_W    = 2,
    parameter int TIMEOUT  = 16
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic [N_CACHES-1:0]          req_i,
    input  logic [2*N_CACHES-1:0]        req_op_i,
    input  logic [ADDR_W*N_CACHES-1:0]   req_addr_i,
    input  logic [N_CACHES-1:0]          snoop_wb_i,
    input  logic                         mem_ack_i,
    output logic [N_CACHES-1:0]          grant_o,
    output logic                         bus_valid_o,
    output logic [1:0]                   bus_op_o,
    output logic [ADDR_W-1:0]            bus_addr_o,
    output logic [SRC_W-1:0]             bus_src_o,
    output logic                         mem_req_o,
    output logic                         mem_we_o,
    output logic [N_CACHES-1:0]          done_o,
    output logic                         busy_o,
    output logic                         err_o
);

    if (SRC_W != $clog2(N_CACHES)) begin : g_bad_src_w
        $error("SRC_W must equal clog2(N_CACHES)");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    arb_state_e          state_q, state_d;
    logic [SRC_W-1:0]    src_q, src_d;
    logic [1:0]          op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [N_CACHES-1:0] eligible;
    logic [N_CACHES-1:0] rr_gnt;
    logic [SRC_W-1:0]    rr_idx;
    logic                rr_valid;
    logic                rr_accept;
    logic [N_CACHES-1:0] owner_mask;
    logic [N_CACHES-1:0] other_wb;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timed_out_q, timed_out_d;
`endif

    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_CACHES; i++) begin
            eligible[i] = req_i[i] && op_is_live(req_op_i[2*i +: 2]);
        end
    end

    snoop_bus_arbiter_rr #(
        .N     (N_CACHES),
        .IDX_W (SRC_W)
    ) u_rr (
        .clock_i  (clock_i),
        .reset_i  (reset_i),
        .req_i    (eligible),
        .accept_i (rr_accept),
        .gnt_o    (rr_gnt),
        .idx_o    (rr_idx),
        .valid_o  (rr_valid)
    );

    assign owner_mask = N_CACHES'(1) << src_q;
    // The owner's own snoop response never counts as a remote writeback.
    assign other_wb   = snoop_wb_i & ~owner_mask;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        op_d      = op_q;
        addr_d    = addr_q;
        rr_accept = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timed_out_d = timed_out_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (rr_valid) begin
                    rr_accept = 1'b1;
                    src_d     = rr_idx;
                    for (int i = 0; i < N_CACHES; i++) begin
                        if (rr_gnt[i]) begin
                            op_d   = req_op_i[2*i +: 2];
                            addr_d = req_addr_i[ADDR_W*i +: ADDR_W];
                        end
                    end
                    state_d = ST_BCAST;
                end
            end
            ST_BCAST: state_d = ST_SNOOP;
            ST_SNOOP: begin
                if (|other_wb) begin
                    state_d = ST_WB;
                end else if (op_q == OP_INV) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MEM;
                end
`ifdef ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
            end
            ST_WB: begin
                if (mem_ack_i) begin
                    state_d = (op_q == OP_INV) ? ST_DONE : ST_MEM;
`ifdef ARB_TIMEOUT_EN
                    cnt_d = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_MEM: begin
                if (mem_ack_i) begin
                    state_d = ST_DONE;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_DONE;
                    timed_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
                timed_out_d = 1'b0;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            op_q    <= OP_NULL;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q       <= '0;
            timed_out_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign err_o = (state_q == ST_DONE) && timed_out_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o      = (state_q != ST_IDLE);
    assign grant_o     = busy_o ? owner_mask : '0;
    assign bus_valid_o = (state_q == ST_BCAST);
    assign bus_op_o    = bus_valid_o ? op_q : OP_NULL;
    assign bus_addr_o  = addr_q;
    assign bus_src_o   = src_q;
    assign mem_req_o   = (state_q == ST_WB) || (state_q == ST_MEM);
    assign mem_we_o    = (state_q == ST_WB);
    assign done_o      = (state_q == ST_DONE) ? owner_mask : '0;

    a_single_wb: assert property (@(posedge clock_i) disable iff (reset_i)
        (state_q == ST_SNOOP) |-> ($countones(other_wb) <= 1));

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - directed table-driven bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;
    import snoop_bus_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int SW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [N-1:0]  req = '0;
    logic [2*N-1:0] req_op = '1;
    logic [AW*N-1:0] req_addr = '0;
    logic [N-1:0]  snoop_wb = '0;
    logic          mem_ack = 1'b0;
    logic [N-1:0]  grant;
    logic          bus_valid;
    logic [1:0]    bus_op;
    logic [AW-1:0] bus_addr;
    logic [SW-1:0] bus_src;
    logic          mem_req, mem_we;
    logic [N-1:0]  done;
    logic          busy, err;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    snoop_bus_arbiter #(
        .N_CACHES (N), .ADDR_W (AW), .SRC_W (SW), .TIMEOUT (16)
    ) dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .req_i       (req),
        .req_op_i    (req_op),
        .req_addr_i  (req_addr),
        .snoop_wb_i  (snoop_wb),
        .mem_ack_i   (mem_ack),
        .grant_o     (grant),
        .bus_valid_o (bus_valid),
        .bus_op_o    (bus_op),
        .bus_addr_o  (bus_addr),
        .bus_src_o   (bus_src),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .done_o      (done),
        .busy_o      (busy),
        .err_o       (err)
    );

    typedef struct {
        int         c;
        logic [1:0] op;
        logic [7:0] addr;
        logic [3:0] wb;
        int         dly;
        int         e_bv;
        logic [1:0] e_op;
        logic [7:0] e_addr;
        int         e_src;
        int         e_wbc;
        int         e_memc;
        int         e_mfirst;
        int         e_done;
        logic [3:0] e_dv;
        int         e_g;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_grant"},     32'(grant),     32'd0);
        check({pfx, "_bus_valid"}, 32'(bus_valid), 32'd0);
        check({pfx, "_bus_op"},    32'(bus_op),    32'd3);
        check({pfx, "_bus_addr"},  32'(bus_addr),  32'd0);
        check({pfx, "_bus_src"},   32'(bus_src),   32'd0);
        check({pfx, "_mem_req"},   32'(mem_req),   32'd0);
        check({pfx, "_mem_we"},    32'(mem_we),    32'd0);
        check({pfx, "_done"},      32'(done),      32'd0);
        check({pfx, "_busy"},      32'(busy),      32'd0);
        check({pfx, "_err"},       32'(err),       32'd0);
    endtask

    task automatic run_vec(input int i);
        vec_t       v;
        int         bv = -1, wbc = 0, memc = 0, mfirst = -1, donec = -1, gc = 0, opbad = 0, ph = 0, bsrc = -1;
        logic [1:0] bop = OP_NULL;
        logic [7:0] badr = '0;
        logic [3:0] dv = '0;
        logic       prev_req = 1'b0, prev_we = 1'b0;
        v = vecs[i];
        req = '0;
        req[v.c] = 1'b1;
        req_op[2*v.c +: 2] = v.op;
        req_addr[8*v.c +: 8] = v.addr;
        snoop_wb = v.wb;
        mem_ack = 1'b0;
        for (int k = 1; k <= 30 && donec < 0; k++) begin
            tick();
            if (bus_valid) begin
                bv = k; bop = bus_op; badr = bus_addr; bsrc = int'(bus_src);
            end else if (bus_op != OP_NULL) begin
                opbad++;
            end
            if (busy && grant == (4'b0001 << v.c)) gc++;
            if (mem_req && mem_we) wbc++;
            if (mem_req && !mem_we) begin
                memc++;
                if (mfirst < 0) mfirst = k;
            end
            if (done != '0) begin
                donec = k; dv = done; req = '0;
            end
            if (mem_req && prev_req && mem_we == prev_we) ph++;
            else ph = 0;
            prev_req = mem_req;
            prev_we  = mem_we;
            mem_ack  = mem_req && (ph >= v.dly);
        end
        req = '0; mem_ack = 1'b0; snoop_wb = '0;
        tick();
        check($sformatf("v%0d_bv_cycle", i), bv, v.e_bv);
        if (v.e_bv >= 0) begin
            check($sformatf("v%0d_bus_op", i),   32'(bop),  32'(v.e_op));
            check($sformatf("v%0d_bus_addr", i), 32'(badr), 32'(v.e_addr));
            check($sformatf("v%0d_bus_src", i),  bsrc,      v.e_src);
        end
        check($sformatf("v%0d_wb_cycles", i),    wbc,     v.e_wbc);
        check($sformatf("v%0d_mem_cycles", i),   memc,    v.e_memc);
        check($sformatf("v%0d_mem_first", i),    mfirst,  v.e_mfirst);
        check($sformatf("v%0d_done_cycle", i),   donec,   v.e_done);
        check($sformatf("v%0d_done_vec", i),     32'(dv), 32'(v.e_dv));
        check($sformatf("v%0d_grant_cycles", i), gc,      v.e_g);
        check($sformatf("v%0d_op_idle_null", i), opbad,   0);
    endtask

    initial begin
        int         found;
        int         n;
        int         order[5];
        logic [7:0] oaddr[5];
        int         memc, donec, dseen, eseen;
        logic       errv;

        //            c  op        addr   wb       dly bv op        addr   src wbc memc mfirst done dv       g
        vecs[0] = '{1, OP_RMISS, 8'h3C, 4'b0000, 0,  1, OP_RMISS, 8'h3C, 1,  0,  1,   3,     4,  4'b0010, 4};
        vecs[1] = '{2, OP_INV,   8'h10, 4'b0000, 0,  1, OP_INV,   8'h10, 2,  0,  0,  -1,     3,  4'b0100, 3};
        vecs[2] = '{0, OP_WMISS, 8'h22, 4'b1000, 2,  1, OP_WMISS, 8'h22, 0,  3,  3,   6,     9,  4'b0001, 9};
        vecs[3] = '{3, OP_INV,   8'h55, 4'b0001, 0,  1, OP_INV,   8'h55, 3,  1,  0,  -1,     4,  4'b1000, 4};
        vecs[4] = '{2, OP_RMISS, 8'hA7, 4'b0100, 0,  1, OP_RMISS, 8'hA7, 2,  0,  1,   3,     4,  4'b0100, 4};
        vecs[5] = '{1, OP_RMISS, 8'hFF, 4'b0001, 0,  1, OP_RMISS, 8'hFF, 1,  1,  1,   4,     5,  4'b0010, 5};
        vecs[6] = '{0, OP_WMISS, 8'h00, 4'b0000, 1,  1, OP_WMISS, 8'h00, 0,  0,  2,   3,     5,  4'b0001, 5};
        vecs[7] = '{3, OP_NULL,  8'h99, 4'b0000, 0, -1, OP_NULL,  8'h00, -1, 0,  0,  -1,    -1,  4'b0000, 0};

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);

        // Reset while waiting on a fill abandons the transaction.
        req = '0; req[1] = 1'b1; req_op[3:2] = OP_RMISS; req_addr[15:8] = 8'h44; mem_ack = 1'b0;
        found = 0;
        for (int k = 0; k < 10 && found == 0; k++) begin
            tick();
            if (mem_req && !mem_we) found = 1;
        end
        check("rst_reach_mem", found, 1);
        reset = 1'b1;
        tick();
        check_reset_outputs("rst_mid");
        reset = 1'b0;
        req = '0;
        tick();
        check("rst_no_done_after", 32'(done), 32'd0);

        // Continuous requests from all caches: order must rotate from pointer 0.
        req = 4'b1111;
        req_op = {4{OP_RMISS}};
        req_addr = {8'h40, 8'h30, 8'h20, 8'h10};
        n = 0;
        for (int j = 0; j < 5; j++) begin
            order[j] = -1;
            oaddr[j] = '0;
        end
        for (int k = 0; k < 80 && n < 5; k++) begin
            tick();
            if (bus_valid) begin
                order[n] = int'(bus_src);
                oaddr[n] = bus_addr;
                n++;
            end
            mem_ack = mem_req;
        end
        check("rr_count", n, 5);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("rr_order%0d", j), order[j], j % 4);
            check($sformatf("rr_addr%0d", j), 32'(oaddr[j]), 32'(8'h10 * ((j % 4) + 1)));
        end
        req = '0;
        for (int k = 0; k < 20 && busy; k++) begin
            tick();
            mem_ack = mem_req;
        end
        mem_ack = 1'b0;
        check("rr_drained", 32'(busy), 32'd0);

        // Memory never acknowledges.
        req = '0; req[2] = 1'b1; req_op[5:4] = OP_RMISS; mem_ack = 1'b0;
        memc = 0; donec = -1; dseen = 0; eseen = 0; errv = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= 40 && donec < 0; k++) begin
            tick();
            if (mem_req && !mem_we) memc++;
            if (done != '0) begin
                donec = k; errv = err; req = '0;
            end
        end
        check("to_done_cycle", donec, 19);
        check("to_mem_cycles", memc, 16);
        check("to_err", 32'(errv), 32'd1);
        req = '0;
        tick();
`else
        for (int k = 1; k <= 102; k++) begin
            tick();
            if (mem_req && !mem_we) memc++;
            if (done != '0) dseen++;
            if (err) eseen++;
        end
        check("wait_mem_cycles", memc, 100);
        check("wait_no_done", dseen, 0);
        check("wait_no_err", eseen, 0);
        check("wait_still_busy", 32'(busy && mem_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = '0;
        tick();
`endif
        check("final_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Shares the single snooping coherence bus among N per-cache MSI controllers.
- Each controller raises a bus request carrying its CDB output code (read miss / invalidate / write miss).
- Arbiter grants round-robin, broadcasts the granted transaction to all snoopers, collects snoop writeback flags, and sequences memory writeback/fill before signalling completion.
- Sits between the cache state machines and the memory port.

Parameters:
- N_CACHES, 4, number of requesting cache controllers (2..8)
- ADDR_W, 8, block address width
- SRC_W, 2, width of source index; must equal clog2(N_CACHES)
- TIMEOUT, 16, memory-wait watchdog limit in cycles; used only with ARB_TIMEOUT_EN

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  N_CACHES  per-cache bus request
- req_op  in  2*N_CACHES  per-cache op: 00 read miss, 01 invalidate, 10 write miss, 11 null
- req_addr  in  ADDR_W*N_CACHES  per-cache block address
- snoop_wb  in  N_CACHES  snooper holds block exclusive and must write back
- mem_ack  in  1  memory completed current access
- grant  out  N_CACHES  one-hot owner of bus
- bus_valid  out  1  broadcast strobe
- bus_op  out  2  broadcast op
- bus_addr  out  ADDR_W  broadcast address
- bus_src  out  SRC_W  index of granted cache
- mem_req  out  1  memory access request
- mem_we  out  1  1 = writeback, 0 = fill
- done  out  N_CACHES  one-cycle completion pulse to owner
- busy  out  1  transaction in progress
- err  out  1  timeout pulse (0 when feature disabled)

Behaviour:
- Reset values: all outputs 0 except bus_op = 2'b11. State IDLE, RR pointer 0, latched txn cleared. Reset mid-transaction abandons it; no done pulse.
- A request is eligible when req[i] = 1 and req_op[i] != 11. Null requests are ignored.
- Round-robin search starts at the pointer. After granting i, pointer = (i+1) mod N_CACHES.
- States:
  - IDLE: if any request is eligible, latch index/op/addr → BCAST.
  - BCAST (1 cycle): bus_valid = 1; bus_op/bus_addr/bus_src driven from latch → SNOOP.
  - SNOOP (1 cycle): sample snoop_wb with the owner's bit masked.
    - Any bit set → WB.
    - Else op == 01 → DONE.
    - Else → MEM.
  - WB: mem_req = 1, mem_we = 1 until mem_ack; then op == 01 → DONE, else → MEM.
  - MEM: mem_req = 1, mem_we = 0 until mem_ack → DONE.
  - DONE (1 cycle): done[owner] = 1 → IDLE.
- grant and busy are high from BCAST through DONE inclusive.
- bus_op returns to 11 and bus_addr/bus_src hold their last value outside BCAST.
- mem_ack is ignored unless mem_req = 1. An ack in the first cycle of WB/MEM is legal (single-cycle memory).
- Latency (request seen in IDLE at cycle t):
  - invalidate, no wb: done at t+3
  - miss, no wb, immediate ack: done at t+4
  - miss with wb, immediate acks: done at t+5
- More than one unmasked snoop_wb bit is a protocol violation: treated as one writeback; simulation assertion fires.
- The owner must drop req in the done cycle. If req is still high in IDLE, it is re-arbitrated normally; round-robin prevents starvation.
- Requests arriving while busy wait. Inputs are re-sampled only in IDLE.

Optional Feature:
- ARB_TIMEOUT_EN defined:
  - Cycle counter clears on entry to WB/MEM.
  - If mem_ack is absent for TIMEOUT cycles, drop mem_req, go to DONE, and pulse err together with done.
- Undefined: WB/MEM wait indefinitely; err tied 0; no counter logic.

Decomposition:
- Shared include snoop_defs.vh holds:
  - op encodings OP_RMISS/OP_INV/OP_WMISS/OP_NULL
  - arbiter state encodings
  - the reuse note for the per-cache controller op codes
- Sub-module rr_arbiter (N-way round-robin, req vector → one-hot grant + index, pointer update on accept) is natural.

Test Plan:
- Reset, then cache1 req op 00 addr 0x3C, mem_ack tied 1 → bus_valid at t+1 with op 00 addr 0x3C src 1; mem_req/mem_we = 1/0 at t+3; done[1] at t+4.
- Cache2 invalidate addr 0x10, snoop_wb = 0 → no mem_req ever; done[2] at t+3.
- Cache0 write miss 0x22, snoop_wb[3] = 1 in SNOOP, acks delayed 2 cycles → WB phase with mem_we = 1, then MEM phase with mem_we = 0, then done[0].
- All four caches request continuously with op 00 → grants in order 0,1,2,3,0; no cache is granted twice before the others.
- Assert reset during MEM → next cycle all outputs 0, bus_op 11, no done; pointer 0 on the following grant.
- With ARB_TIMEOUT_EN, TIMEOUT 16, mem_ack held 0 → err and done pulse on cycle 16 of MEM; without the macro, still waiting at cycle 100.
